// File: rtl/am_pkg.sv
// Shared constants and types for the AM modulator datapath.
// Gain LUT is Q0.8; entries past DEPTH_MAX are never selected.
package am_pkg;

  localparam int DEPTH_MAX = 10;

  typedef logic [3:0] depth_idx_t;

  localparam logic [7:0] GAIN_LUT [16] = '{
    8'd0,   8'd13,  8'd28,  8'd45,
    8'd64,  8'd85,  8'd110, 8'd138,
    8'd171, 8'd209, 8'd255, 8'd0,
    8'd0,   8'd0,   8'd0,   8'd0
  };

  function automatic int am_offset(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/am_depth_ctrl.sv
// Modulation depth register; AM_DEPTH_SWEEP_EN adds a
// MANUAL/SWEEP FSM that steps depth every SWEEP_TICKS cycles.
module am_depth_ctrl
  import am_pkg::*;
#(
  parameter int DEPTH_INIT  = 5,
  parameter int SWEEP_TICKS = 30000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       depth_load,
  input  depth_idx_t depth_cfg,
  output depth_idx_t depth_cur
);

  localparam depth_idx_t INIT = depth_idx_t'(DEPTH_INIT);
  localparam depth_idx_t DMAX = depth_idx_t'(DEPTH_MAX);

  if (DEPTH_INIT > DEPTH_MAX || SWEEP_TICKS < 1) begin : g_param_err
    $error("am_depth_ctrl: bad DEPTH_INIT or SWEEP_TICKS");
  end

  depth_idx_t depth_q;
  depth_idx_t depth_d;
  logic       load_ok;

  assign load_ok   = depth_load && (depth_cfg <= DMAX);
  assign depth_cur = depth_q;

`ifdef AM_DEPTH_SWEEP_EN
  localparam int CW =
    (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SWEEP_TICKS - 1);

  typedef enum logic {MANUAL, SWEEP} mode_t;

  mode_t         state_q;
  mode_t         state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sweep_req;
  logic          sweeping;

  assign sweep_req = depth_load && (depth_cfg == 4'd15);
  assign sweeping  = (state_q == SWEEP) && !load_ok && !sweep_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    unique case (1'b1)
      load_ok: begin
        state_d = MANUAL;
        cnt_d   = '0;
        depth_d = depth_cfg;
      end
      sweep_req: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      sweeping: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          depth_d = (depth_q == DMAX) ? '0 : depth_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      depth_q <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
    end
  end
`else
  always_comb begin
    depth_d = depth_q;
    if (load_ok) depth_d = depth_cfg;
  end

  always_ff @(posedge clk_in) begin
    if (rst) depth_q <= INIT;
    else     depth_q <= depth_d;
  end
`endif

endmodule

// File: rtl/am_mod_pipe.sv
// 4-stage AM modulator: sum -> gain -> offset -> carrier mult.
// Optional depth sweep mode: define AM_DEPTH_SWEEP_EN.
module am_mod_pipe
  import am_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NCH         = 2,
  parameter int DEPTH_INIT  = 5,
  parameter int SWEEP_TICKS = 30000,
  localparam int SW    = DATA_W + $clog2(NCH),
  localparam int ENV_W = SW + 1,
  localparam int OUT_W = ENV_W + DATA_W
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     carrier,
  input  logic [NCH*DATA_W-1:0] jidai,
  input  logic [3:0]            depth_cfg,
  input  logic                  depth_load,
  output logic [3:0]            depth_cur,
  output logic [SW-1:0]         he_jidai,
  output logic [OUT_W-1:0]      modulate,
  output logic                  out_valid
);

  localparam int PW = SW + 8;
  localparam logic [ENV_W-1:0] OFFSET = ENV_W'(am_offset(DATA_W));

  logic [SW-1:0]     sum;
  logic [7:0]        gain;
  logic [PW-1:0]     prod_q;
  logic [ENV_W-1:0]  env_q;
  logic [DATA_W-1:0] car1_q, car2_q, car3_q;
  logic              v1_q, v2_q, v3_q;

  am_depth_ctrl #(
    .DEPTH_INIT  (DEPTH_INIT),
    .SWEEP_TICKS (SWEEP_TICKS)
  ) u_depth (
    .clk_in     (clk_in),
    .rst        (rst),
    .depth_load (depth_load),
    .depth_cfg  (depth_cfg),
    .depth_cur  (depth_cur)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++)
      sum = sum + SW'(jidai[i*DATA_W +: DATA_W]);
  end

  // Gain is picked from depth_cur as the sample enters S2,
  // so one sample never sees two depths.
  assign gain = GAIN_LUT[depth_cur];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      he_jidai  <= '0;
      prod_q    <= '0;
      env_q     <= '0;
      modulate  <= '0;
      car1_q    <= '0;
      car2_q    <= '0;
      car3_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      he_jidai  <= sum;
      v1_q      <= in_valid;
      car1_q    <= carrier;
      prod_q    <= PW'(he_jidai) * PW'(gain);
      v2_q      <= v1_q;
      car2_q    <= car1_q;
      env_q     <= ENV_W'(prod_q[PW-1:8]) + OFFSET;
      v3_q      <= v2_q;
      car3_q    <= car2_q;
      modulate  <= OUT_W'(env_q) * OUT_W'(car3_q);
      out_valid <= v3_q;
    end
  end

endmodule
